// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit event counter display.
// Segment patterns are ordered {a,b,c,d,e,f,g} (a in bit 6) and active-low:
// a 0 bit lights the segment.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;  // lower-case b
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;  // lower-case d
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Wrap-blink sequence: two blank/show pairs, then back to idle.
   typedef enum logic [2:0] {
      BLINK_IDLE   = 3'd0,
      BLINK_BLANK1 = 3'd1,
      BLINK_SHOW1  = 3'd2,
      BLINK_BLANK2 = 3'd3,
      BLINK_SHOW2  = 3'd4
   } blink_state_e;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational 4-bit digit to active-low 7-segment pattern (0-9, A b C d E F).
module seg7_encoder
   import seg7_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   // Digit lookup; every code is listed so the default never shows in practice.
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_event_counter.sv
// Event counter driving a two-digit active-low 7-segment display.
// Counts i_inc/i_dec strobes (BCD 00..99 or hex 00..FF), pulses o_wrap on
// wrap-around, and registers the segment outputs one edge after the count.
// Optional feature macro SEG7_WRAP_BLINK_EN: blink the display twice after a wrap.
module seg7_event_counter
   import seg7_pkg::*;
#(
   parameter int DECIMAL    = 1,
   parameter int BLINK_HALF = 2500000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_inc,
   input  logic       i_dec,
   input  logic       i_clr,
   output logic [7:0] o_count,
   output logic       o_wrap,
   output logic       o_seg1a,
   output logic       o_seg1b,
   output logic       o_seg1c,
   output logic       o_seg1d,
   output logic       o_seg1e,
   output logic       o_seg1f,
   output logic       o_seg1g,
   output logic       o_seg2a,
   output logic       o_seg2b,
   output logic       o_seg2c,
   output logic       o_seg2d,
   output logic       o_seg2e,
   output logic       o_seg2f,
   output logic       o_seg2g
);

   logic [7:0] count_q, count_d;
   logic       wrap_q, wrap_d;
   logic [6:0] seg1_q, seg1_d;
   logic [6:0] seg2_q, seg2_d;
   logic [3:0] tens, ones;
   logic [6:0] enc1, enc2;
   logic       blank_d;

   assign tens = count_q[7:4];
   assign ones = count_q[3:0];

   // Next count: clear wins, inc+dec together cancel, then inc, then dec.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (i_clr) begin
         count_d = 8'h00;
      end else if (i_inc && !i_dec) begin
         if (DECIMAL != 0) begin
            if (ones == 4'd9) begin
               if (tens == 4'd9) begin
                  count_d = 8'h00;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = {tens + 4'd1, 4'd0};
               end
            end else begin
               count_d = {tens, ones + 4'd1};
            end
         end else begin
            count_d = count_q + 8'd1;
            wrap_d  = (count_q == 8'hFF);
         end
      end else if (i_dec && !i_inc) begin
         if (DECIMAL != 0) begin
            if (ones == 4'd0) begin
               if (tens == 4'd0) begin
                  count_d = 8'h99;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = {tens - 4'd1, 4'd9};
               end
            end else begin
               count_d = {tens, ones - 4'd1};
            end
         end else begin
            count_d = count_q - 8'd1;
            wrap_d  = (count_q == 8'h00);
         end
      end
   end

   seg7_encoder u_enc_tens (.i_digit(tens), .o_seg(enc1));
   seg7_encoder u_enc_ones (.i_digit(ones), .o_seg(enc2));

`ifdef SEG7_WRAP_BLINK_EN
   localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BCW-1:0] HALF_LAST = BCW'(BLINK_HALF - 1);

   blink_state_e   state_q, state_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;

   // Blink sequencer: any wrap pulse (re)starts at BLANK1; each state lasts BLINK_HALF cycles.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      if (wrap_q) begin
         state_d = BLINK_BLANK1;
         bcnt_d  = '0;
      end else if (state_q != BLINK_IDLE) begin
         if (bcnt_q == HALF_LAST) begin
            bcnt_d = '0;
            case (state_q)
               BLINK_BLANK1: state_d = BLINK_SHOW1;
               BLINK_SHOW1:  state_d = BLINK_BLANK2;
               BLINK_BLANK2: state_d = BLINK_SHOW2;
               default:      state_d = BLINK_IDLE;
            endcase
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
      // Blanking follows the state being entered so the registered display
      // lines up cycle-for-cycle with the state register.
      blank_d = (state_d == BLINK_BLANK1) || (state_d == BLINK_BLANK2);
   end

   // Blink state and half-period counter registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= BLINK_IDLE;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end
`else
   // Without the blink feature the display always shows the count; BLINK_HALF
   // is folded into a deliberately unused net.
   logic unused_blink_half;
   assign unused_blink_half = ^BLINK_HALF;
   assign blank_d = 1'b0;
`endif

   // Display data for the next edge: blank pattern or the current count.
   always_comb begin
      seg1_d = blank_d ? SEG_BLANK : enc1;
      seg2_d = blank_d ? SEG_BLANK : enc2;
   end

   // Count, wrap pulse and display registers; reset shows "00".
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= 8'h00;
         wrap_q  <= 1'b0;
         seg1_q  <= SEG_0;
         seg2_q  <= SEG_0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         seg1_q  <= seg1_d;
         seg2_q  <= seg2_d;
      end
   end

   assign o_count = count_q;
   assign o_wrap  = wrap_q;
   assign {o_seg1a, o_seg1b, o_seg1c, o_seg1d, o_seg1e, o_seg1f, o_seg1g} = seg1_q;
   assign {o_seg2a, o_seg2b, o_seg2c, o_seg2d, o_seg2e, o_seg2f, o_seg2g} = seg2_q;

endmodule
